// File: rtl/alu_pkg.sv
// Shared ctrl encodings and sequencer states for alu_seq.
// ALU_DIV_EN adds the DIV state used by the iterative divider.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0100;
   localparam logic [3:0] ALU_SRA  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_MULU = 4'b1000;
   localparam logic [3:0] ALU_DIVU = 4'b1010;
   localparam logic [3:0] ALU_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
`ifdef ALU_DIV_EN
      StDiv  = 2'd2,
`endif
      StDone = 2'd3
   } alu_state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply and, with ALU_DIV_EN,
// restoring divide. last_o marks the edge that completes the final iteration.
module alu_seq_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
`ifdef ALU_DIV_EN
   input  logic             div_i,
`endif
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam logic [SHW:0] LastCnt = (SHW+1)'(WIDTH - 1);
   localparam logic [SHW:0] CntOne  = (SHW+1)'(1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q;
   logic [SHW:0]     cnt_q;
   logic             busy_q;
   logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
   logic             div_q;
   logic [WIDTH:0]   div_rem;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
`endif

   always_comb begin
      // {acc, lo} holds the partial product; lo shifts out multiplier bits.
      mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      acc_d   = mul_sum[WIDTH:1];
      lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
      // lo shifts dividend bits into the remainder and quotient bits in.
      div_rem  = {acc_q, lo_q[WIDTH-1]};
      div_diff = div_rem[WIDTH-1:0] - opnd_q;
      div_ge   = (div_rem >= {1'b0, opnd_q});
      if (div_q) begin
         acc_d = div_ge ? div_diff : div_rem[WIDTH-1:0];
         lo_d  = {lo_q[WIDTH-2:0], div_ge};
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q  <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
`ifdef ALU_DIV_EN
         div_q  <= 1'b0;
`endif
      end else if (start_i) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
`ifdef ALU_DIV_EN
         div_q  <= div_i;
         opnd_q <= div_i ? b_i : a_i;
         lo_q   <= div_i ? a_i : b_i;
`else
         opnd_q <= a_i;
         lo_q   <= b_i;
`endif
      end else if (busy_q) begin
         acc_q <= acc_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + CntOne;
         if (cnt_q == LastCnt) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign last_o = busy_q && (cnt_q == LastCnt);
   assign lo_o   = lo_q;
   assign hi_o   = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshake and iterative MULU.
// Defining ALU_DIV_EN adds the iterative DIVU (code 1010).
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ctrl_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic             zero_o,
   output logic             overflow_o
);

   localparam int unsigned SHW = $clog2(WIDTH);

   alu_state_t       state_q;
   logic             valid_q, zero_q, ovf_q;
   logic [WIDTH-1:0] result_q, result_hi_q;

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum, diff, sc_res;
   logic             sc_ovf;
   logic             is_mul, is_multi, iter_start, iter_last;
   logic [WIDTH-1:0] iter_lo, iter_hi;
`ifdef ALU_DIV_EN
   logic             is_div;
   assign is_div   = (ctrl_i == ALU_DIVU);
   assign is_multi = is_mul || is_div;
`else
   assign is_multi = is_mul;
`endif

   assign shamt      = src2_i[SHW-1:0];
   assign sum        = src1_i + src2_i;
   assign diff       = src1_i - src2_i;
   assign is_mul     = (ctrl_i == ALU_MULU);
   assign ready_o    = (state_q == StIdle);
   assign iter_start = valid_i && ready_o && is_multi;

   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (ctrl_i)
         ALU_AND: sc_res = src1_i & src2_i;
         ALU_OR:  sc_res = src1_i | src2_i;
         ALU_NOR: sc_res = ~(src1_i | src2_i);
         ALU_ADD: begin
            sc_res = sum;
            sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
         end
         ALU_SUB: begin
            sc_res = diff;
            sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
         end
         ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
         ALU_SLL: sc_res = src1_i << shamt;
         ALU_SRL: sc_res = src1_i >> shamt;
         ALU_SRA: sc_res = $unsigned($signed(src1_i) >>> shamt);
         default: ;
      endcase
   end

   alu_seq_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(iter_start),
`ifdef ALU_DIV_EN
      .div_i  (is_div),
`endif
      .a_i    (src1_i),
      .b_i    (src2_i),
      .last_o (iter_last),
      .lo_o   (iter_lo),
      .hi_o   (iter_hi)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= StIdle;
         valid_q     <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (valid_i) begin
                  if (is_mul) begin
                     state_q <= StMul;
`ifdef ALU_DIV_EN
                  end else if (is_div) begin
                     state_q <= StDiv;
`endif
                  end else begin
                     valid_q     <= 1'b1;
                     result_q    <= sc_res;
                     result_hi_q <= '0;
                     zero_q      <= (sc_res == '0);
                     ovf_q       <= sc_ovf;
                  end
               end
            end
            StMul: if (iter_last) state_q <= StDone;
`ifdef ALU_DIV_EN
            StDiv: if (iter_last) state_q <= StDone;
`endif
            StDone: begin
               state_q     <= StIdle;
               valid_q     <= 1'b1;
               result_q    <= iter_lo;
               result_hi_q <= iter_hi;
               zero_q      <= (iter_lo == '0);
               ovf_q       <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign valid_o     = valid_q;
   assign result_o    = result_q;
   assign result_hi_o = result_hi_q;
   assign zero_o      = zero_q;
   assign overflow_o  = ovf_q;

endmodule
